// File: rtl/instr_mem_responder.sv
// -----------------------------------------------------------------------------
// instr_mem_responder
//   Fetch-side instruction memory for the single-cycle CPU. A fetch request
//   (PC + READ) is accepted in IDLE. BUSYWAIT stays high for LATENCY edges.
//   The 32-bit little-endian word then appears with a one-cycle VALID pulse.
//   A byte-wide program port can write the memory in any state.
//
// Ports
//   CLK          in   clock, all state updates on posedge
//   RESET        in   synchronous active-high reset (memory contents kept)
//   PC           in   byte address of the requested instruction
//   READ         in   fetch request level, sampled at posedge in IDLE
//   INSTRUCTION  out  fetched word {m[a+3],m[a+2],m[a+1],m[a]}, held between
//                     VALID pulses, 32'hFFFF_FFFF on a bad address
//   VALID        out  one-cycle pulse, INSTRUCTION updated this cycle
//   BUSYWAIT     out  CPU must stall its PC while high
//   ERROR        out  one-cycle pulse with VALID on a bad address
//   PROG_EN      in   program-port byte write enable
//   PROG_ADDR    in   program-port byte address
//   PROG_DATA    in   program-port byte data
// -----------------------------------------------------------------------------
module instr_mem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 4     // legal range 1..15
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [31:0]           PC,
   input  logic                  READ,
   output logic [31:0]           INSTRUCTION,
   output logic                  VALID,
   output logic                  BUSYWAIT,
   output logic                  ERROR,
   input  logic                  PROG_EN,
   input  logic [ADDR_WIDTH-1:0] PROG_ADDR,
   input  logic [7:0]            PROG_DATA
);

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

   localparam logic [32:0] MEM_BYTES = 33'd1 << ADDR_WIDTH;
   localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

   state_t                state;
   state_t                state_next;
   logic [3:0]            cnt;
   logic [31:0]           addr_q;
   logic [7:0]            mem [2**ADDR_WIDTH];

   logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
   logic                  bad_addr;
   logic                  fetch_done;
   logic [31:0]           word;

   // Byte indices stay inside the array even for a bad address. The word
   // read through them is discarded in that case, so no out-of-range access.
   assign a0 = addr_q[ADDR_WIDTH-1:0];
   assign a1 = a0 + ADDR_WIDTH'(1);
   assign a2 = a0 + ADDR_WIDTH'(2);
   assign a3 = a0 + ADDR_WIDTH'(3);

   // The check is done in 33 bits so that upper PC bits count as out of range
   // and a word straddling the top of memory never wraps around to address 0.
   assign bad_addr   = (addr_q[1:0] != 2'b00) ||
                       (({1'b0, addr_q} + 33'd3) >= MEM_BYTES);
   assign word       = {mem[a3], mem[a2], mem[a1], mem[a0]};
   assign fetch_done = (state == FETCH) && (cnt == 4'd0);

   assign BUSYWAIT = ~RESET & (((state == IDLE) & READ) | (state == FETCH));

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the edge.
   always_ff @(posedge CLK) begin
      if (RESET) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: the default assignment comes first so that no path leaves
   // state_next unassigned, which would infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (READ) state_next = FETCH;
         FETCH:   if (cnt == 4'd0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt         <= 4'd0;
         addr_q      <= 32'h0;
         INSTRUCTION <= 32'h0;
         VALID       <= 1'b0;
         ERROR       <= 1'b0;
      end else begin
         VALID <= fetch_done;
         ERROR <= fetch_done & bad_addr;
         case (state)
            IDLE: begin
               if (READ) begin
                  addr_q <= PC;
                  cnt    <= CNT_INIT;
               end
            end
            FETCH: begin
               if (cnt == 4'd0) INSTRUCTION <= bad_addr ? 32'hFFFF_FFFF : word;
               else             cnt         <= cnt - 4'd1;
            end
            default: ;
         endcase
      end
   end

   // NOTE: the memory array has no reset. A program-port write on the same
   // edge as the final fetch read gives the old byte, because INSTRUCTION
   // samples mem before this update lands.
   always_ff @(posedge CLK) begin
      if (PROG_EN) mem[PROG_ADDR] <= PROG_DATA;
   end

endmodule

// File: tb/tb_instr_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_responder
//   Directed bench for instr_mem_responder. It uses a LATENCY=4 instance, plus
//   a LATENCY=1 instance that shares the clock, reset and program port.
//   Expected words come from a byte model of the memory. A fetch pushes its
//   expected word onto a scoreboard, and the entry is popped when VALID is seen.
// -----------------------------------------------------------------------------
module tb_instr_mem_responder;

   localparam int LAT = 4;

   typedef struct packed {
      logic [31:0] word;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, read, read1, prog_en;
   logic [31:0] pc, pc1;
   logic [9:0]  prog_addr;
   logic [7:0]  prog_data;
   logic [31:0] instr, instr1;
   logic        valid, valid1, busy, busy1, err, err1;

   exp_t        sb[$];
   logic [7:0]  model_mem [0:1023];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          v0, v1, vd;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   instr_mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
      .CLK(clk), .RESET(reset), .PC(pc), .READ(read),
      .INSTRUCTION(instr), .VALID(valid), .BUSYWAIT(busy), .ERROR(err),
      .PROG_EN(prog_en), .PROG_ADDR(prog_addr), .PROG_DATA(prog_data)
   );

   instr_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
      .CLK(clk), .RESET(reset), .PC(pc1), .READ(read1),
      .INSTRUCTION(instr1), .VALID(valid1), .BUSYWAIT(busy1), .ERROR(err1),
      .PROG_EN(prog_en), .PROG_ADDR(prog_addr), .PROG_DATA(prog_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] mword(input int a);
      return {model_mem[a+3], model_mem[a+2], model_mem[a+1], model_mem[a]};
   endfunction

   // Called just after a negedge. The byte lands on the next posedge.
   task automatic prog(input int a, input logic [7:0] d);
      prog_en   = 1'b1;
      prog_addr = 10'(a);
      prog_data = d;
      model_mem[a] = d;
      @(negedge clk);
      prog_en = 1'b0;
   endtask

   // Waits for VALID, which should come exp_n negedges from now. BUSYWAIT
   // should be high on exp_bw of the negedges before it. Pops the scoreboard.
   task automatic wait_valid(input string tag, input int exp_n, input int exp_bw,
                             output int vcyc);
      int   bw = 0;
      bit   seen = 1'b0;
      exp_t e;
      vcyc = 0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(negedge clk);
         if (valid) begin
            seen = 1'b1;
            vcyc = cyc;
            check({tag, " latency"}, i, exp_n);
            check({tag, " busy cycles"}, bw, exp_bw);
            check({tag, " busy in valid"}, {31'b0, busy}, 32'h0);
            if (sb.size() == 0) begin
               check({tag, " unexpected valid"}, {31'b0, valid}, 32'h0);
            end else begin
               e = sb.pop_front();
               check({tag, " word"}, instr, e.word);
               check({tag, " error"}, {31'b0, err}, {31'b0, e.err});
            end
         end else if (busy) begin
            bw++;
         end
      end
      if (!seen) check({tag, " timeout"}, {31'b0, valid}, 32'h1);
   endtask

   // One READ pulse from IDLE, then wait for the result.
   task automatic do_fetch(input string tag, input logic [31:0] a,
                           input logic [31:0] w, input logic e);
      int v;
      @(negedge clk);
      pc   = a;
      read = 1'b1;
      sb.push_back('{word: w, err: e});
      #1 check({tag, " busy on request"}, {31'b0, busy}, 32'h1);
      @(negedge clk);
      read = 1'b0;
      wait_valid(tag, LAT, LAT - 1, v);
   endtask

   initial begin
      reset = 1'b1; read = 1'b1; read1 = 1'b0; pc = 0; pc1 = 0;
      prog_en = 1'b0; prog_addr = '0; prog_data = '0;
      repeat (2) @(negedge clk);

      // Reset state: BUSYWAIT is forced low even with READ high.
      check("reset instr", instr, 32'h0);
      check("reset valid", {31'b0, valid}, 32'h0);
      check("reset error", {31'b0, err}, 32'h0);
      check("reset busy", {31'b0, busy}, 32'h0);
      check("reset instr lat1", instr1, 32'h0);
      reset = 1'b0;
      read  = 1'b0;

      // Preload memory through the program port.
      prog(0, 8'h05); prog(1, 8'h00); prog(2, 8'h04); prog(3, 8'h00);
      prog(4, 8'h13); prog(5, 8'h00); prog(6, 8'h50); prog(7, 8'h00);
      prog(1020, 8'h78); prog(1021, 8'h56); prog(1022, 8'h34); prog(1023, 8'h12);

      // 1: basic fetch, then INSTRUCTION holds its value.
      do_fetch("t1", 0, 32'h0004_0005, 1'b0);
      repeat (3) @(negedge clk);
      check("t1 hold", instr, 32'h0004_0005);
      check("t1 valid low", {31'b0, valid}, 32'h0);

      // 2: READ held high, two back-to-back fetches. A PC change during FETCH
      // is ignored. The pulses are LAT+2 cycles apart.
      @(negedge clk);
      pc = 0; read = 1'b1;
      sb.push_back('{word: 32'h0004_0005, err: 1'b0});
      @(negedge clk);
      pc = 4;
      sb.push_back('{word: 32'h0050_0013, err: 1'b0});
      wait_valid("t2a", LAT, LAT - 1, v0);
      wait_valid("t2b", LAT + 2, LAT + 1, v1);
      read = 1'b0;
      check("t2 spacing", v1 - v0, LAT + 2);

      // 3: bad addresses, the aligned top word, and memory left intact.
      do_fetch("t3 misaligned", 2, 32'hFFFF_FFFF, 1'b1);
      do_fetch("t3 overrun", 1022, 32'hFFFF_FFFF, 1'b1);
      do_fetch("t3 top word", 1020, 32'h1234_5678, 1'b0);
      do_fetch("t3 past end", 1024, 32'hFFFF_FFFF, 1'b1);
      do_fetch("t3 upper bits", 32'h0001_0000, 32'hFFFF_FFFF, 1'b1);
      do_fetch("t3 intact", 0, 32'h0004_0005, 1'b0);

      // 4: a program write on the final FETCH edge returns the old word.
      @(negedge clk);
      pc = 0; read = 1'b1;
      sb.push_back('{word: 32'h0004_0005, err: 1'b0});
      @(negedge clk);
      read = 1'b0;
      repeat (LAT - 1) @(negedge clk);
      prog_en = 1'b1; prog_addr = 10'd1; prog_data = 8'hAA;
      model_mem[1] = 8'hAA;
      wait_valid("t4 old", 1, 0, vd);
      prog_en = 1'b0;
      do_fetch("t4 new", 0, 32'h0004_AA05, 1'b0);
      check("t4 model", mword(0), 32'h0004_AA05);

      // 5: reset two cycles into FETCH abandons the request.
      @(negedge clk);
      pc = 4; read = 1'b1;
      @(negedge clk);
      read = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1 check("t5 busy in reset", {31'b0, busy}, 32'h0);
      @(negedge clk);
      check("t5 instr", instr, 32'h0);
      check("t5 valid", {31'b0, valid}, 32'h0);
      reset = 1'b0;
      for (int i = 0; i < LAT + 2; i++) begin
         @(negedge clk);
         check("t5 no valid", {31'b0, valid}, 32'h0);
         check("t5 busy low", {31'b0, busy}, 32'h0);
      end
      do_fetch("t5 after", 4, 32'h0050_0013, 1'b0);

      // 6: LATENCY=1 instance. VALID comes one edge after accept, and a PC
      // change during FETCH is ignored.
      @(negedge clk);
      pc1 = 0; read1 = 1'b1;
      #1 check("t6 busy on request", {31'b0, busy1}, 32'h1);
      @(negedge clk);
      pc1 = 4; read1 = 1'b0;
      check("t6 not yet valid", {31'b0, valid1}, 32'h0);
      check("t6 busy in fetch", {31'b0, busy1}, 32'h1);
      @(negedge clk);
      check("t6 valid", {31'b0, valid1}, 32'h1);
      check("t6 word", instr1, 32'h0004_AA05);
      check("t6 error", {31'b0, err1}, 32'h0);
      check("t6 busy in valid", {31'b0, busy1}, 32'h0);

      check("sb drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
